// File: rtl/popcount24_weight_enum.sv
// Enumerates every N-bit word of popcount k in ascending order, one per handshake.
// A Gosper step produces the successor word in a single cycle.
module popcount24_weight_enum #(
  parameter int N  = 24,
  parameter int CW = 5,
  parameter int IW = 22
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [CW-1:0] k,
  output logic          busy,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_word,
  output logic [CW-1:0] out_k,
  output logic [IW-1:0] word_idx,
  output logic          out_last,
  output logic          done,
  output logic          err
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t state, state_nxt;

  logic          run;
  logic          accept;
  logic          start_ok;
  logic          start_bad;
  logic          last_hit;
  logic [N-1:0]  ones;
  logic [N-1:0]  first_w;
  logic [N-1:0]  last_w;
  logic [N-1:0]  next_w;
  logic [N:0]    w_ext;
  logic [N:0]    c;
  logic [N:0]    r;
  logic [CW-1:0] tz;

  assign run       = (state == RUN);
  assign ones      = '1;
  assign first_w   = ~(ones << k);
  assign last_w    = ~(ones >> out_k);
  assign last_hit  = (out_word == last_w);
  assign accept    = run && out_ready;
  assign start_ok  = !run && start && (k <= CW'(N));
  assign start_bad = !run && start && (k > CW'(N));

  // Shift by ctz(w) stands in for the divide by the lowest set bit.
  always_comb begin
    w_ext = {1'b0, out_word};
    c     = w_ext & (~w_ext + (N+1)'(1));
    r     = w_ext + c;
    tz    = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (out_word[i]) tz = CW'(i);
    end
    next_w = N'(r | (((r ^ w_ext) >> 2) >> tz));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (1'b1)
      (state == IDLE): if (start_ok) state_nxt = RUN;
      (state == RUN):  if (accept && last_hit) state_nxt = IDLE;
      default:         state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy      = run;
    out_valid = run;
    out_last  = run && last_hit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_word <= '0;
      out_k    <= '0;
      word_idx <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      err  <= start_bad;
      done <= accept && last_hit;
      if (start_ok) begin
        out_k    <= k;
        out_word <= first_w;
        word_idx <= '0;
      end else if (accept && !last_hit) begin
        out_word <= next_w;
        word_idx <= word_idx + IW'(1);
      end
    end
  end

endmodule

// File: tb/tb_popcount24_weight_enum.sv
// Bench for popcount24_weight_enum: random stalls and starts checked
// against a bit-scanning successor model and binomial word counts.
module tb_popcount24_weight_enum;
  localparam int N  = 24;
  localparam int CW = 5;
  localparam int IW = 22;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] k = '0;
  logic          busy;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [N-1:0]  out_word;
  logic [CW-1:0] out_k;
  logic [IW-1:0] word_idx;
  logic          out_last;
  logic          done;
  logic          err;

  int tests = 0;
  int fails = 0;

  popcount24_weight_enum #(.N(N), .CW(CW), .IW(IW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .k(k),
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
    .out_word(out_word), .out_k(out_k), .word_idx(word_idx),
    .out_last(out_last), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [N-1:0] ref_first(input int kk);
    logic [N-1:0] w = '0;
    for (int j = 0; j < kk; j++) w[j] = 1'b1;
    return w;
  endfunction

  function automatic logic [N-1:0] ref_last(input int kk);
    logic [N-1:0] w = '0;
    for (int j = 0; j < kk; j++) w[N-1-j] = 1'b1;
    return w;
  endfunction

  // Lowest "01" pair moves up one place; the ones below it drop to the LSBs.
  function automatic logic [N-1:0] ref_next(input logic [N-1:0] w);
    logic [N-1:0] r = w;
    int pos = 0;
    int m = 0;
    while (pos < N - 1 && !(w[pos] && !w[pos+1])) begin
      if (w[pos]) m++;
      pos++;
    end
    for (int j = 0; j <= pos; j++) r[j] = 1'b0;
    r[pos+1] = 1'b1;
    for (int j = 0; j < m; j++) r[j] = 1'b1;
    return r;
  endfunction

  function automatic int binom(input int n, input int kk);
    longint r = 1;
    for (int j = 0; j < kk; j++) r = r * (n - j) / (j + 1);
    return int'(r);
  endfunction

  task automatic start_enum(input int kk);
    @(negedge clk);
    start = 1'b1;
    k = CW'(kk);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic stream(input int kk, input int pct, input bit poke,
                        output int count);
    logic [N-1:0] exp_w;
    logic [N-1:0] prev_w;
    logic [N-1:0] lw;
    bit got_last = 0;
    int cyc = 0;
    int budget;
    exp_w  = ref_first(kk);
    prev_w = '0;
    lw     = ref_last(kk);
    count  = 0;
    budget = 4 * binom(N, kk) + 50;
    forever begin
      if (cyc++ > budget) begin
        tests++; fails++;
        $display("FAIL stream_timeout k=%0d words=%0d", kk, count);
        break;
      end
      if (got_last) begin
        tests++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b1 ||
            out_word !== prev_w) begin
          fails++;
          $display("FAIL end_of_run k=%0d got v=%b b=%b d=%b w=%h exp 0 0 1 %h",
                   kk, out_valid, busy, done, out_word, prev_w);
        end
        break;
      end
      tests++;
      if (out_valid !== 1'b1 || busy !== 1'b1 || out_k !== CW'(kk)) begin
        fails++;
        $display("FAIL run_state k=%0d got v=%b b=%b k=%0d", kk,
                 out_valid, busy, out_k);
        break;
      end
      tests++;
      if (out_word !== exp_w || word_idx !== IW'(count) ||
          out_last !== (exp_w == lw) || $countones(out_word) != kk) begin
        fails++;
        $display("FAIL word k=%0d got w=%h i=%0d l=%b exp w=%h i=%0d l=%b",
                 kk, out_word, word_idx, out_last, exp_w, count, exp_w == lw);
      end
      out_ready = ($urandom_range(99) < pct);
      start = poke && ($urandom_range(1) == 1);
      k = CW'($urandom_range(31));
      if (out_ready) begin
        count++;
        prev_w = exp_w;
        if (exp_w == lw) got_last = 1;
        else exp_w = ref_next(exp_w);
      end
      @(negedge clk);
    end
    out_ready = 1'b0;
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if ({busy, out_valid, out_last, done, err} !== 5'b0 ||
        out_word !== '0 || out_k !== '0 || word_idx !== '0) begin
      fails++;
      $display("FAIL reset got b%b v%b l%b d%b e%b w=%h k=%0d i=%0d exp zeros",
               busy, out_valid, out_last, done, err, out_word, out_k, word_idx);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_k1();
    int n;
    start_enum(1);
    stream(1, 100, 0, n);
    tests++;
    if (n != 24) begin
      fails++;
      $display("FAIL k1_count got %0d exp 24", n);
    end
    @(negedge clk);
    tests++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL k1_done_pulse got d=%b b=%b exp 0 0", done, busy);
    end
  endtask

  task automatic test_k2();
    int n;
    start_enum(2);
    stream(2, 100, 0, n);
    tests++;
    if (n != 276) begin
      fails++;
      $display("FAIL k2_count got %0d exp 276", n);
    end
  endtask

  task automatic test_edges();
    int n;
    start_enum(0);
    stream(0, 100, 0, n);
    tests++;
    if (n != 1) begin
      fails++;
      $display("FAIL k0_count got %0d exp 1", n);
    end
    start_enum(24);
    stream(24, 70, 0, n);
    tests++;
    if (n != 1) begin
      fails++;
      $display("FAIL k24_count got %0d exp 1", n);
    end
    start_enum(25);
    tests++;
    if (err !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL k25_err got e=%b v=%b b=%b exp 1 0 0", err, out_valid, busy);
    end
    @(negedge clk);
    tests++;
    if (err !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL k25_after got e=%b v=%b b=%b exp 0 0 0", err, out_valid, busy);
    end
  endtask

  task automatic test_back_to_back();
    start_enum(0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    start = 1'b1;
    k = CW'(24);
    tests++;
    if (done !== 1'b1 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL b2b_done got d=%b v=%b exp 1 0", done, out_valid);
    end
    @(negedge clk);
    start = 1'b0;
    tests++;
    if (out_valid !== 1'b1 || out_word !== 24'hFFFFFF || out_last !== 1'b1 ||
        done !== 1'b0 || word_idx !== '0) begin
      fails++;
      $display("FAIL b2b_restart got v=%b w=%h l=%b d=%b i=%0d exp 1 ffffff 1 0 0",
               out_valid, out_word, out_last, done, word_idx);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_stall_k3();
    int n;
    start_enum(3);
    stream(3, 50, 1, n);
    tests++;
    if (n != 2024) begin
      fails++;
      $display("FAIL k3_count got %0d exp 2024", n);
    end
  endtask

  task automatic test_reset_midrun();
    int n;
    int cyc = 0;
    start_enum(12);
    out_ready = 1'b1;
    while (word_idx !== IW'(1000) && cyc < 1100) begin
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b0;
    tests++;
    if (word_idx !== IW'(1000) || out_valid !== 1'b1) begin
      fails++;
      $display("FAIL midrun_reach got i=%0d v=%b exp 1000 1", word_idx, out_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({busy, out_valid, out_last, done, err} !== 5'b0 ||
        out_word !== '0 || out_k !== '0 || word_idx !== '0) begin
      fails++;
      $display("FAIL async_reset got b%b v%b w=%h k=%0d i=%0d exp zeros",
               busy, out_valid, out_word, out_k, word_idx);
    end
    @(negedge clk);
    rst_n = 1'b1;
    start_enum(5);
    stream(5, 100, 0, n);
    tests++;
    if (n != 42504) begin
      fails++;
      $display("FAIL k5_count got %0d exp 42504", n);
    end
  endtask

  task automatic test_sweep();
    int ks[8] = '{0, 1, 4, 20, 21, 22, 23, 24};
    int n;
    foreach (ks[i]) begin
      start_enum(ks[i]);
      stream(ks[i], 90, 0, n);
      tests++;
      if (n != binom(N, ks[i])) begin
        fails++;
        $display("FAIL sweep_count k=%0d got %0d exp %0d", ks[i], n,
                 binom(N, ks[i]));
      end
    end
  endtask

  initial begin
    test_reset();
    test_k1();
    test_k2();
    test_edges();
    test_back_to_back();
    test_stall_k3();
    test_reset_midrun();
    test_sweep();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
